// File: rtl/llr_trans_pipe.sv
// Two-stage streaming symbol-to-LLR translator with a programmable LUT and an
// optional saturating +1 correction on masked fields.
module llr_trans_pipe #(
    parameter int INPUT_BIT = 3,
    parameter int LLR_BIT   = 3,
    parameter int FIELD     = 3,
    parameter int NUM_CH    = 2
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              CIM_E,
    input  logic                              IN_VALID,
    output logic                              IN_READY,
    input  logic [NUM_CH*INPUT_BIT-1:0]       IN_SYM,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic [NUM_CH*FIELD*LLR_BIT-1:0]   OUT_LLR,
    input  logic                              CFG_WE,
    input  logic [INPUT_BIT-1:0]              CFG_ADDR,
    input  logic [FIELD*LLR_BIT-1:0]          CFG_LLR,
    input  logic [FIELD-1:0]                  CFG_MASK
);

    localparam int DEPTH   = 1 << INPUT_BIT;
    localparam int ENTRY_W = FIELD * LLR_BIT;
    localparam int OUT_W   = NUM_CH * ENTRY_W;
    localparam int MSK_W   = NUM_CH * FIELD;

    function automatic logic [LLR_BIT-1:0] sat_inc(input logic [LLR_BIT-1:0] v);
        return (&v) ? v : v + LLR_BIT'(1);
    endfunction

    logic [ENTRY_W-1:0] lut_llr_q  [DEPTH];
    logic [FIELD-1:0]   lut_mask_q [DEPTH];

    logic               s1_vld_q, s2_vld_q;
    logic               s1_cim_q;
    logic [OUT_W-1:0]   s1_llr_q, s1_llr_d;
    logic [MSK_W-1:0]   s1_mask_q, s1_mask_d;
    logic [OUT_W-1:0]   s2_llr_q, s2_llr_d;

    logic s2_load, s1_load, in_fire;

    assign s2_load  = !s2_vld_q || OUT_READY;
    assign s1_load  = !s1_vld_q || s2_load;
    assign in_fire  = IN_VALID && s1_load;
    assign IN_READY = s1_load;

    assign OUT_VALID = s2_vld_q;
    assign OUT_LLR   = s2_llr_q;

    // LUT: a read in the same cycle as a write to that entry sees the old contents.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut_llr_q[i]  <= '0;
                lut_mask_q[i] <= '0;
            end
        end else if (CFG_WE) begin
            lut_llr_q[CFG_ADDR]  <= CFG_LLR;
            lut_mask_q[CFG_ADDR] <= CFG_MASK;
        end
    end

    always_comb begin
        s1_llr_d  = '0;
        s1_mask_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s1_llr_d[c*ENTRY_W +: ENTRY_W] = lut_llr_q[IN_SYM[c*INPUT_BIT +: INPUT_BIT]];
            s1_mask_d[c*FIELD +: FIELD]    = lut_mask_q[IN_SYM[c*INPUT_BIT +: INPUT_BIT]];
        end
    end

    // Field index i = c*FIELD + f lines up the mask bit with its LLR slot.
    always_comb begin
        s2_llr_d = '0;
        for (int i = 0; i < MSK_W; i++) begin
            if (s1_cim_q && s1_mask_q[i])
                s2_llr_d[i*LLR_BIT +: LLR_BIT] = sat_inc(s1_llr_q[i*LLR_BIT +: LLR_BIT]);
            else
                s2_llr_d[i*LLR_BIT +: LLR_BIT] = s1_llr_q[i*LLR_BIT +: LLR_BIT];
        end
    end

    // Stage 1: LUT lookup and sampled correction enable
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_vld_q  <= 1'b0;
            s1_cim_q  <= 1'b0;
            s1_llr_q  <= '0;
            s1_mask_q <= '0;
        end else begin
            if (s1_load)
                s1_vld_q <= in_fire;
            if (in_fire) begin
                s1_cim_q  <= CIM_E;
                s1_llr_q  <= s1_llr_d;
                s1_mask_q <= s1_mask_d;
            end
        end
    end

    // Stage 2: corrected LLRs, held while downstream stalls
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_vld_q <= 1'b0;
            s2_llr_q <= '0;
        end else if (s2_load) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q)
                s2_llr_q <= s2_llr_d;
        end
    end

endmodule

// File: tb/tb_llr_trans_pipe.sv
// Bench for llr_trans_pipe: directed vector table on a default-size instance and
// randomised handshake traffic on a wide instance, both checked via scoreboards.
module tb_llr_trans_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Default-size instance
    logic        a_cim, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cfg_we;
    logic [5:0]  a_in_sym;
    logic [17:0] a_out_llr;
    logic [2:0]  a_cfg_addr, a_cfg_mask;
    logic [8:0]  a_cfg_llr;

    llr_trans_pipe u_dut_a (
        .CLK(clk), .RST_N(rst_n), .CIM_E(a_cim),
        .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .IN_SYM(a_in_sym),
        .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .OUT_LLR(a_out_llr),
        .CFG_WE(a_cfg_we), .CFG_ADDR(a_cfg_addr), .CFG_LLR(a_cfg_llr), .CFG_MASK(a_cfg_mask)
    );

    // Wide instance for randomised traffic
    logic        b_cim, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cfg_we;
    logic [15:0] b_in_sym;
    logic [47:0] b_out_llr;
    logic [3:0]  b_cfg_addr;
    logic [11:0] b_cfg_llr;
    logic [2:0]  b_cfg_mask;

    llr_trans_pipe #(.INPUT_BIT(4), .LLR_BIT(4), .FIELD(3), .NUM_CH(4)) u_dut_b (
        .CLK(clk), .RST_N(rst_n), .CIM_E(b_cim),
        .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_SYM(b_in_sym),
        .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_LLR(b_out_llr),
        .CFG_WE(b_cfg_we), .CFG_ADDR(b_cfg_addr), .CFG_LLR(b_cfg_llr), .CFG_MASK(b_cfg_mask)
    );

    logic [17:0] qa[$];
    logic [47:0] qb[$];
    logic [11:0] mb_llr  [16];
    logic [2:0]  mb_mask [16];

    typedef struct {
        logic [5:0]  sym;
        logic        cim;
        logic [17:0] exp;
    } vec_t;
    vec_t tbl[8];

    // Per-channel expected entries, packed {f2,f1,f0}
    localparam logic [8:0] E0  = {3'd0, 3'd1, 3'd2};
    localparam logic [8:0] E0C = {3'd1, 3'd1, 3'd2};
    localparam logic [8:0] E1  = {3'd0, 3'd2, 3'd1};
    localparam logic [8:0] E1C = {3'd1, 3'd2, 3'd1};
    localparam logic [8:0] E2  = {3'd3, 3'd7, 3'd7};
    localparam logic [8:0] E2C = {3'd4, 3'd7, 3'd7};
    localparam logic [8:0] E3  = {3'd1, 3'd1, 3'd2};
    localparam logic [8:0] E3N = {3'd2, 3'd0, 3'd0};
    localparam logic [8:0] E7  = 9'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] model_b(input logic [15:0] sym, input logic cim);
        logic [47:0] r;
        logic [3:0]  s, v;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            s = sym[c*4 +: 4];
            for (int f = 0; f < 3; f++) begin
                v = mb_llr[s][f*4 +: 4];
                if (cim && mb_mask[s][f])
                    v = (v == 4'd15) ? 4'd15 : v + 4'd1;
                r[(c*3+f)*4 +: 4] = v;
            end
        end
        return r;
    endfunction

    task automatic cfg_a(input logic [2:0] addr, input logic [8:0] llr, input logic [2:0] mask);
        a_cfg_we = 1'b1; a_cfg_addr = addr; a_cfg_llr = llr; a_cfg_mask = mask;
        @(posedge clk); #1;
        a_cfg_we = 1'b0;
    endtask

    task automatic cfg_b(input logic [3:0] addr, input logic [11:0] llr, input logic [2:0] mask);
        b_cfg_we = 1'b1; b_cfg_addr = addr; b_cfg_llr = llr; b_cfg_mask = mask;
        @(posedge clk); #1;
        b_cfg_we = 1'b0;
        mb_llr[addr] = llr;
        mb_mask[addr] = mask;
    endtask

    // Presents one beat and pushes its expectation on the cycle it is accepted.
    task automatic send(input logic [5:0] sym, input logic cim, input logic [17:0] exp);
        bit done;
        done = 0;
        a_in_valid = 1'b1; a_in_sym = sym; a_cim = cim;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (a_in_ready) begin
                qa.push_back(exp);
                @(posedge clk); #1;
                done = 1;
            end
        end
        a_in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: actual=no handshake required=handshake sym=%0h", sym);
        end
    endtask

    // Output monitor A: scoreboard pop plus hold-while-stalled check
    logic        a_stalled_prev = 1'b0;
    logic [17:0] a_held = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_stalled_prev <= 1'b0;
        end else begin
            if (a_stalled_prev) begin
                chk("stall_hold_llr", 64'(a_out_llr), 64'(a_held));
                chk("stall_hold_vld", 64'(a_out_valid), 64'(1));
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_unexpected_out: actual=%0h required=none", a_out_llr);
                end else begin
                    chk("a_out_llr", 64'(a_out_llr), 64'(qa.pop_front()));
                end
            end
            a_stalled_prev <= a_out_valid && !a_out_ready;
            a_held <= a_out_llr;
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected_out: actual=%0h required=none", b_out_llr);
            end else begin
                chk("b_out_llr", 64'(b_out_llr), 64'(qb.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{6'({3'd1, 3'd0}), 1'b0, {E1,  E0 }};
        tbl[1] = '{6'({3'd0, 3'd1}), 1'b0, {E0,  E1 }};
        tbl[2] = '{6'({3'd1, 3'd0}), 1'b1, {E1C, E0C}};
        tbl[3] = '{6'({3'd0, 3'd1}), 1'b1, {E0C, E1C}};
        tbl[4] = '{6'({3'd2, 3'd2}), 1'b1, {E2C, E2C}};
        tbl[5] = '{6'({3'd2, 3'd0}), 1'b0, {E2,  E0 }};
        tbl[6] = '{6'({3'd0, 3'd2}), 1'b1, {E0C, E2C}};
        tbl[7] = '{6'({3'd7, 3'd3}), 1'b1, {E7,  E3 }};
        for (int i = 0; i < 16; i++) begin
            mb_llr[i] = '0;
            mb_mask[i] = '0;
        end

        a_cim = 0; a_in_valid = 0; a_in_sym = '0; a_out_ready = 1; a_cfg_we = 0;
        a_cfg_addr = '0; a_cfg_llr = '0; a_cfg_mask = '0;
        b_cim = 0; b_in_valid = 0; b_in_sym = '0; b_out_ready = 1; b_cfg_we = 0;
        b_cfg_addr = '0; b_cfg_llr = '0; b_cfg_mask = '0;

        repeat (3) @(posedge clk);
        #3;
        chk("rst_out_valid", 64'(a_out_valid), 64'(0));
        chk("rst_out_llr", 64'(a_out_llr), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(a_in_ready), 64'(1));

        cfg_a(3'd0, E0, 3'b100);
        cfg_a(3'd1, E1, 3'b100);
        cfg_a(3'd2, E2, 3'b111);
        cfg_a(3'd3, E3, 3'b000);

        send(tbl[0].sym, tbl[0].cim, tbl[0].exp);
        @(negedge clk);
        chk("latency_1cyc_vld", 64'(a_out_valid), 64'(0));
        @(negedge clk);
        chk("latency_2cyc_vld", 64'(a_out_valid), 64'(1));
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            send(tbl[i].sym, tbl[i].cim, tbl[i].exp);
        repeat (4) @(posedge clk);
        #1;
        chk("table_drain", 64'(qa.size()), 64'(0));

        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(tbl[i].sym, tbl[i].cim, tbl[i].exp);
            end
            begin
                repeat (3) @(posedge clk);
                #1 a_out_ready = 1'b0;
                @(negedge clk);
                chk("full_in_ready", 64'(a_in_ready), 64'(0));
                chk("full_out_valid", 64'(a_out_valid), 64'(1));
                repeat (4) @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("stall_drain", 64'(qa.size()), 64'(0));

        fork
            cfg_a(3'd3, E3N, 3'b000);
            send(6'({3'd3, 3'd3}), 1'b0, {E3, E3});
        join
        send(6'({3'd3, 3'd3}), 1'b0, {E3N, E3N});
        repeat (4) @(posedge clk);
        #1;
        chk("wr_bypass_drain", 64'(qa.size()), 64'(0));

        a_out_ready = 1'b0;
        send(6'({3'd3, 3'd3}), 1'b0, {E3N, E3N});
        send(6'({3'd2, 3'd2}), 1'b0, {E2, E2});
        #2;
        chk("pre_rst_vld", 64'(a_out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(a_out_valid), 64'(0));
        chk("midrst_out_llr", 64'(a_out_llr), 64'(0));
        qa.delete();
        for (int i = 0; i < 16; i++) begin
            mb_llr[i] = '0;
            mb_mask[i] = '0;
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_vld", 64'(a_out_valid), 64'(0));
        send(6'({3'd0, 3'd0}), 1'b1, 18'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_drain", 64'(qa.size()), 64'(0));

        cfg_b(4'd0, 12'hFFF, 3'b111);
        for (int a = 1; a < 16; a++)
            cfg_b(4'(a), 12'($urandom), 3'($urandom));
        for (int k = 0; k < 600; k++) begin
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_sym    = 16'($urandom);
            b_cim       = 1'($urandom);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_cfg_we    = ($urandom_range(0, 7) == 0);
            b_cfg_addr  = 4'($urandom);
            b_cfg_llr   = 12'($urandom);
            b_cfg_mask  = 3'($urandom);
            @(negedge clk);
            if (b_in_valid && b_in_ready)
                qb.push_back(model_b(b_in_sym, b_cim));
            if (b_cfg_we) begin
                mb_llr[b_cfg_addr] = b_cfg_llr;
                mb_mask[b_cfg_addr] = b_cfg_mask;
            end
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        b_cfg_we = 1'b0;
        b_out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rand_drain", 64'(qb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
